// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [7:0]      opcode_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state;
    logic [7:0]          op;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;
    logic                neg;
    logic [CNT_W-1:0]    cnt;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Acceptance-time decode: signedness, magnitudes, result sign and fast path.
    logic signed [XLEN-1:0] op1_s, op2_s;
    logic                   a_signed, b_signed, a_neg, b_neg;
    logic                   in_div, in_rem, div_zero, ovf, fast;
    logic [XLEN-1:0]        a_mag, b_mag, fast_res;

    assign op1_s = op1_i;
    assign op2_s = op2_i;

    always_comb begin
        a_signed = opcode_i[0] | opcode_i[1] | opcode_i[2] | opcode_i[4] | opcode_i[6];
        b_signed = opcode_i[0] | opcode_i[1] | opcode_i[4] | opcode_i[6];
        a_neg    = a_signed && (op1_s < 0);
        b_neg    = b_signed && (op2_s < 0);
        a_mag    = cond_neg(op1_i, a_neg);
        b_mag    = cond_neg(op2_i, b_neg);
        in_div   = |opcode_i[7:4];
        in_rem   = opcode_i[6] | opcode_i[7];
        div_zero = in_div && (op2_i == '0);
        ovf      = (opcode_i[4] | opcode_i[6]) && (op1_i == MIN_NEG) && (op2_i == '1);
        fast     = !$onehot(opcode_i) || div_zero || ovf;
        fast_res = '0;
        if (!$onehot(opcode_i))
            fast_res = '0;
        else if (div_zero)
            fast_res = in_rem ? op1_i : '1;
        else if (ovf)
            fast_res = in_rem ? '0 : op1_i;
    end

    // One iteration of either algorithm; acc holds {hi, lo}.
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge, is_div_q;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        is_div_q  = |op[7:4];
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[XLEN-1:0] - opnd;
        div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod = cond_neg_wide(acc, neg);
        if (op[0])
            fix_res = prod[XLEN-1:0];
        else if (op[1] | op[2] | op[3])
            fix_res = prod[2*XLEN-1:XLEN];
        else if (op[4] | op[5])
            fix_res = cond_neg(acc[XLEN-1:0], neg);
        else
            fix_res = cond_neg(acc[2*XLEN-1:XLEN], neg);
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            res_o   <= '0;
            cnt     <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op   <= opcode_i;
                        opnd <= in_div ? b_mag : a_mag;
                        acc  <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
                        neg  <= in_rem ? a_neg : (a_neg ^ b_neg);
                        cnt  <= '0;
                        if (fast) begin
                            res_o   <= fast_res;
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= is_div_q ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    res_o   <= fix_res;
                    valid_o <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, fast paths,
// backpressure, reset and flush aborts.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [31:0] op1_i, op2_i, res_o;
    logic [7:0]  opcode_i;
    int          tests = 0;
    int          fails = 0;
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op1_i(op1_i), .op2_i(op2_i), .opcode_i(opcode_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode_i = op; op1_i = a; op2_i = b; valid_i = 1'b1;
        check("ready_at_accept", {31'b0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0; op1_i = '1; op2_i = '1; opcode_i = 8'h00;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!valid_o && l < 100);
        check("valid_arrives", {31'b0, valid_o}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int l;
        accept(op, a, b);
        wait_result(l);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_res"}, res_o, exp_res);
        @(negedge clk);
        check({tag, "_ready_after"}, {31'b0, ready_o}, 32'd1);
        check({tag, "_valid_after"}, {31'b0, valid_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        op1_i = '0; op2_i = '0; opcode_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o},  32'd0);
        check("rst_res",   res_o, 32'h0);

        run_op("mul",    8'h01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh",   8'h02, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu",  8'h08, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhsu", 8'h04, 32'h80000000, 32'h80000000, 32'hC0000000, 34);
        run_op("div",    8'h10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem",    8'h40, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu",   8'h20, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
        run_op("remu",   8'h80, 32'hFFFFFFF9, 32'd2,        32'h00000001, 34);

        run_op("divu_by0",  8'h20, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
        run_op("rem_by0",   8'h40, 32'h1234,     32'h0,        32'h00001234, 1);
        run_op("rem_ovf",   8'h40, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("div_ovf",   8'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("bad_op03",  8'h03, 32'd5,        32'd6,        32'h00000000, 1);
        run_op("bad_op00",  8'h00, 32'd5,        32'd6,        32'h00000000, 1);

        // Backpressure: result must hold in DONE while the consumer stalls.
        ready_i = 1'b0;
        accept(8'h01, 32'd6, 32'd7);
        wait_result(lat);
        check("bp_lat", lat, 34);
        check("bp_res", res_o, 32'd42);
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; opcode_i = 8'h01; op1_i = 32'd9; op2_i = 32'd9;
            @(negedge clk);
            check("bp_hold_valid", {31'b0, valid_o}, 32'd1);
            check("bp_hold_res",   res_o, 32'd42);
            check("bp_hold_ready", {31'b0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_drop_valid", {31'b0, valid_o}, 32'd0);
        check("bp_drop_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        check("bp_no_new_op", {31'b0, busy_o}, 32'd0);

        // Reset in CALC cycle 15.
        accept(8'h01, 32'h12345678, 32'h9ABCDEF0);
        repeat (15) @(negedge clk);
        check("rst_abort_busy_before", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        check("rst_abort_ready", {31'b0, ready_o}, 32'd1);
        check("rst_abort_valid", {31'b0, valid_o}, 32'd0);
        check("rst_abort_busy",  {31'b0, busy_o},  32'd0);
        check("rst_abort_res",   res_o, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("rst_abort_no_valid", seen, 0);

        // Flush in CALC cycle 20.
        accept(8'h02, 32'h12345678, 32'h9ABCDEF0);
        repeat (20) @(negedge clk);
        check("flush_busy_before", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_ready", {31'b0, ready_o}, 32'd1);
        check("flush_valid", {31'b0, valid_o}, 32'd0);
        check("flush_busy",  {31'b0, busy_o},  32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("flush_no_valid", seen, 0);

        // An op presented together with flush is not taken.
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; opcode_i = 8'h01; op1_i = 32'd2; op2_i = 32'd2;
        @(posedge clk);
        #1 valid_i = 1'b0; flush_i = 1'b0;
        check("flush_blocks_accept", {31'b0, busy_o}, 32'd0);

        run_op("mul_after_abort", 8'h01, 32'd3, 32'd5, 32'd15, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
